// File: rtl/lifo_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
package lifo_pkg;

    // Encoding matches the {push, pop} request pair so decode is a plain cast.
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } lifo_op_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module lifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-power-of-two depths leave unused addresses; read those as zero.
    assign rdata = ({1'b0, raddr} < (AW+1)'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with occupancy count, replace-top, threshold flags and sticky errors.
module param_lifo_stack
    import lifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    output logic [WIDTH-1:0]             top,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    lifo_op_e         op;
    logic             wr_en;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;

    assign op = lifo_op_e'({push, pop});

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign top          = empty ? '0 : rdata;

    // A replace overwrites the current top; a push (including push+pop on empty) writes at count.
    always_comb begin
        wr_en = 1'b0;
        waddr = AW'(count);
        raddr = AW'(count - ONE_C);
        if (!clear) begin
            unique case (op)
                OP_PUSH:    wr_en = !full;
                OP_REPLACE: begin
                    wr_en = 1'b1;
                    if (!empty) begin
                        waddr = AW'(count - ONE_C);
                    end
                end
                default:    wr_en = 1'b0;
            endcase
        end
    end

    lifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (din),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            count      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            unique case (op)
                OP_NOP: ;
                OP_PUSH: begin
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + ONE_C;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        dout       <= rdata;
                        dout_valid <= 1'b1;
                        count      <= count - ONE_C;
                    end
                end
                OP_REPLACE: begin
                    if (empty) begin
                        count     <= ONE_C;
                        underflow <= 1'b1;
                    end else begin
                        dout       <= rdata;
                        dout_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed vector bench for param_lifo_stack (WIDTH=8, DEPTH=4, AF=3, AE=1).
module tb_param_lifo_stack;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       clear;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid;
    logic [7:0] top;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int n_cmp;
    int n_err;

    param_lifo_stack #(
        .WIDTH     (8),
        .DEPTH     (4),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .clear        (clear),
        .din          (din),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .top          (top),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flg = {full, empty, almost_full, almost_empty, overflow, underflow}
    typedef struct {
        logic       clr;
        logic       psh;
        logic       pp;
        logic [7:0] d;
        logic [2:0] cnt;
        logic [7:0] dq;
        logic       dv;
        logic [7:0] tp;
        logic [5:0] flg;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic pu, input logic po, input logic [7:0] d);
        @(negedge clk);
        clear = c;
        push  = pu;
        pop   = po;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] flags();
        return {full, empty, almost_full, almost_empty, overflow, underflow};
    endfunction

    task automatic set_vec(input int i, input logic c, input logic pu, input logic po, input logic [7:0] d,
                           input logic [2:0] cn, input logic [7:0] dq, input logic dv,
                           input logic [7:0] tp, input logic [5:0] fl);
        vecs[i].clr = c;  vecs[i].psh = pu; vecs[i].pp = po; vecs[i].d = d;
        vecs[i].cnt = cn; vecs[i].dq = dq;  vecs[i].dv = dv;  vecs[i].tp = tp; vecs[i].flg = fl;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        din   = '0;

        //        clr psh pop din    cnt dout   dv top    flags
        set_vec( 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 6'b010100);
        set_vec( 1, 0, 1, 0, 8'h11, 1, 8'h00, 0, 8'h11, 6'b000100);
        set_vec( 2, 0, 1, 0, 8'h22, 2, 8'h00, 0, 8'h22, 6'b000000);
        set_vec( 3, 0, 1, 0, 8'h33, 3, 8'h00, 0, 8'h33, 6'b001000);
        set_vec( 4, 0, 1, 0, 8'h44, 4, 8'h00, 0, 8'h44, 6'b101000);
        set_vec( 5, 0, 1, 1, 8'hAA, 4, 8'h44, 1, 8'hAA, 6'b101000);
        set_vec( 6, 0, 1, 1, 8'h44, 4, 8'hAA, 1, 8'h44, 6'b101000);
        set_vec( 7, 0, 1, 0, 8'h55, 4, 8'hAA, 0, 8'h44, 6'b101010);
        set_vec( 8, 0, 0, 1, 8'h00, 3, 8'h44, 1, 8'h33, 6'b001010);
        set_vec( 9, 0, 0, 1, 8'h00, 2, 8'h33, 1, 8'h22, 6'b000010);
        set_vec(10, 0, 1, 1, 8'h99, 2, 8'h22, 1, 8'h99, 6'b000010);
        set_vec(11, 0, 0, 1, 8'h00, 1, 8'h99, 1, 8'h11, 6'b000110);
        set_vec(12, 0, 0, 1, 8'h00, 0, 8'h11, 1, 8'h00, 6'b010110);
        set_vec(13, 0, 0, 1, 8'h00, 0, 8'h11, 0, 8'h00, 6'b010111);
        set_vec(14, 0, 1, 1, 8'h7A, 1, 8'h11, 0, 8'h7A, 6'b000111);
        set_vec(15, 1, 1, 0, 8'hEE, 0, 8'h11, 0, 8'h00, 6'b010100);
        set_vec(16, 0, 1, 0, 8'h11, 1, 8'h11, 0, 8'h11, 6'b000100);
        set_vec(17, 0, 1, 0, 8'h22, 2, 8'h11, 0, 8'h22, 6'b000000);
        set_vec(18, 0, 1, 0, 8'h33, 3, 8'h11, 0, 8'h33, 6'b001000);
        set_vec(19, 0, 1, 0, 8'h44, 4, 8'h11, 0, 8'h44, 6'b101000);
        set_vec(20, 0, 0, 1, 8'h00, 3, 8'h44, 1, 8'h33, 6'b001000);
        set_vec(21, 0, 0, 1, 8'h00, 2, 8'h33, 1, 8'h22, 6'b000000);
        set_vec(22, 0, 0, 1, 8'h00, 1, 8'h22, 1, 8'h11, 6'b000100);
        set_vec(23, 0, 0, 1, 8'h00, 0, 8'h11, 1, 8'h00, 6'b010100);
        set_vec(24, 0, 0, 0, 8'h00, 0, 8'h11, 0, 8'h00, 6'b010100);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].clr, vecs[i].psh, vecs[i].pp, vecs[i].d);
            chk("count", i, 32'(count),      32'(vecs[i].cnt));
            chk("dout",  i, 32'(dout),       32'(vecs[i].dq));
            chk("dv",    i, 32'(dout_valid), 32'(vecs[i].dv));
            chk("top",   i, 32'(top),        32'(vecs[i].tp));
            chk("flags", i, 32'(flags()),    32'(vecs[i].flg));
        end

        // Clear together with push while overflow is set at count 3.
        step(0, 1, 0, 8'hA1);
        step(0, 1, 0, 8'hA2);
        step(0, 1, 0, 8'hA3);
        step(0, 1, 0, 8'hA4);
        step(0, 1, 0, 8'hA5);
        step(0, 0, 1, 8'h00);
        chk("pre_clr_count", 100, 32'(count),    32'd3);
        chk("pre_clr_ovf",   100, 32'(overflow), 32'd1);
        chk("pre_clr_dout",  100, 32'(dout),     32'hA4);
        step(1, 1, 0, 8'hEE);
        chk("clr_count", 101, 32'(count),    32'd0);
        chk("clr_ovf",   101, 32'(overflow), 32'd0);
        chk("clr_empty", 101, 32'(empty),    32'd1);
        chk("clr_top",   101, 32'(top),      32'h00);
        step(0, 0, 1, 8'h00);
        chk("post_clr_uf",   102, 32'(underflow),  32'd1);
        chk("post_clr_dv",   102, 32'(dout_valid), 32'd0);
        chk("post_clr_dout", 102, 32'(dout),       32'hA4);
        chk("post_clr_cnt",  102, 32'(count),      32'd0);

        // Asynchronous reset mid-cycle with count 3 and underflow set.
        step(0, 1, 0, 8'hB1);
        step(0, 1, 0, 8'hB2);
        step(0, 1, 0, 8'hB3);
        chk("pre_rst_count", 103, 32'(count), 32'd3);
        step(0, 0, 0, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_count", 104, 32'(count),      32'd0);
        chk("rst_empty", 104, 32'(empty),      32'd1);
        chk("rst_full",  104, 32'(full),       32'd0);
        chk("rst_dout",  104, 32'(dout),       32'h00);
        chk("rst_dv",    104, 32'(dout_valid), 32'd0);
        chk("rst_ovf",   104, 32'(overflow),   32'd0);
        chk("rst_udf",   104, 32'(underflow),  32'd0);
        chk("rst_top",   104, 32'(top),        32'h00);
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 0, 8'hC3);
        chk("post_rst_count", 105, 32'(count), 32'd1);
        chk("post_rst_top",   105, 32'(top),   32'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
